// File: rtl/mips_run_ctrl_if.sv
// Program-load stream and instruction-memory write port between the host
// and the run controller.
interface mips_run_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: loads imem while the core is
// held in reset, then runs it until PC hits halt_pc or the cycle budget runs out.
module mips_run_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CYC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      halt_pc,
  input  logic [CYC_W-1:0] max_cycles,
  mips_run_ctrl_if.slave   ld,
  output logic             core_rst,
  input  logic [31:0]      pc,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles,
  output logic [ADDR_W:0]  words
);

  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, DONE} state_t;

  state_t            state_reg;
  logic              timeout_reg;
  logic [CYC_W-1:0]  cycles_reg;
  logic [ADDR_W:0]   words_reg;
  logic [31:0]       halt_pc_reg;
  logic [CYC_W-1:0]  max_cycles_reg;
  logic              imem_we_reg;
  logic [ADDR_W-1:0] imem_addr_reg;
  logic [DATA_W-1:0] imem_wdata_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      timeout_reg    <= 1'b0;
      cycles_reg     <= '0;
      words_reg      <= '0;
      halt_pc_reg    <= '0;
      max_cycles_reg <= '0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
    end else begin
      imem_we_reg <= 1'b0;
      if (abort) begin
        // Counters are left as-is so the host can inspect an aborted run.
        state_reg   <= IDLE;
        timeout_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            if (start) begin
              state_reg      <= LOAD;
              timeout_reg    <= 1'b0;
              cycles_reg     <= '0;
              words_reg      <= '0;
              halt_pc_reg    <= halt_pc;
              max_cycles_reg <= max_cycles;
            end
          end
          LOAD: begin
            if (ld.ld_valid) begin
              imem_we_reg    <= 1'b1;
              imem_addr_reg  <= words_reg[ADDR_W-1:0];
              imem_wdata_reg <= ld.ld_data;
              words_reg      <= words_reg + 1'b1;
              // The top address is a forced last beat: the memory never wraps.
              if (ld.ld_last || (&words_reg[ADDR_W-1:0])) begin
                state_reg <= RELEASE;
              end
            end
          end
          RELEASE: begin
            state_reg <= RUN;
          end
          RUN: begin
            if (!(&cycles_reg)) begin
              cycles_reg <= cycles_reg + 1'b1;
            end
            if (pc == halt_pc_reg) begin
              state_reg   <= DONE;
              timeout_reg <= 1'b0;
            end else if ((max_cycles_reg != '0) &&
                         (CYC_W'(cycles_reg + 1'b1) == max_cycles_reg)) begin
              state_reg   <= DONE;
              timeout_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign ld.ld_ready   = (state_reg == LOAD);
  assign ld.imem_we    = imem_we_reg;
  assign ld.imem_addr  = imem_addr_reg;
  assign ld.imem_wdata = imem_wdata_reg;

  assign core_rst = (state_reg != RUN);
  assign busy     = (state_reg == LOAD) || (state_reg == RELEASE) || (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign timeout  = timeout_reg;
  assign cycles   = cycles_reg;
  assign words    = words_reg;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Randomized bench for mips_run_ctrl; a simple core model advances pc by 4
// per cycle whenever core_rst is low.
module tb_mips_run_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CYC_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      halt_pc = '0;
  logic [CYC_W-1:0] max_cycles = '0;
  logic [31:0]      pc = '0;
  logic             core_rst, busy, done, timeout;
  logic [CYC_W-1:0] cycles;
  logic [ADDR_W:0]  words;

  int total = 0;
  int bad = 0;
  logic [31:0] prog [0:299];

  mips_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mips_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .halt_pc(halt_pc), .max_cycles(max_cycles), .ld(bus),
    .core_rst(core_rst), .pc(pc), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles), .words(words)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pc <= core_rst ? 32'h0 : pc + 32'd4;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL rst core_rst: got %0b want 1", core_rst); end
    total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL rst ld_ready: got %0b want 0", bus.ld_ready); end
    total++; if (bus.imem_we !== 1'b0) begin bad++; $display("FAIL rst imem_we: got %0b want 0", bus.imem_we); end
    total++; if ({busy, done, timeout} !== 3'b000) begin bad++; $display("FAIL rst flags: got %b want 000", {busy, done, timeout}); end
    total++; if (bus.imem_addr !== '0 || bus.imem_wdata !== '0) begin bad++; $display("FAIL rst imem: got %0h/%0h want 0/0", bus.imem_addr, bus.imem_wdata); end
    total++; if (cycles !== '0 || words !== '0) begin bad++; $display("FAIL rst counters: got %0d/%0d want 0/0", cycles, words); end
    rst = 1'b1;
    $display("reset: checked");
  endtask

  // One full load+run transaction with model-derived expectations.
  task automatic do_run(input string tag, input int n, input bit use_last, input logic [31:0] hpc,
                        input logic [CYC_W-1:0] mc, input int bub, input bit poke);
    int i, guard, lowcnt, exp_words, exp_c, hidx;
    bit drv, exp_to, fin;
    for (int k = 0; k < n; k++) prog[k] = $urandom;
    exp_words = (use_last && n <= (1 << ADDR_W)) ? n : (1 << ADDR_W);
    hidx = (hpc[1:0] == 2'b00 && hpc < 32'h0004_0000) ? int'(hpc >> 2) : -1;
    if (hidx >= 0 && (mc == '0 || hidx + 1 <= int'(mc))) begin exp_c = hidx + 1; exp_to = 1'b0; end
    else begin exp_c = int'(mc); exp_to = 1'b1; end

    @(negedge clk);
    halt_pc = hpc; max_cycles = mc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; halt_pc = ~hpc; max_cycles = mc + 16'd3;
    total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL %s start ld_ready: got %0b want 1", tag, bus.ld_ready); end
    total++; if (words !== '0 || cycles !== '0 || done !== 1'b0) begin bad++; $display("FAIL %s start clear: got w=%0d c=%0d d=%0b want 0/0/0", tag, words, cycles, done); end

    i = 0; drv = 1'b0; guard = 0; fin = 1'b0;
    while (!fin) begin
      total++;
      if (bus.imem_we !== drv) begin bad++; $display("FAIL %s imem_we beat %0d: got %0b want %0b", tag, i, bus.imem_we, drv); end
      if (drv) begin
        total++;
        if (bus.imem_addr !== ADDR_W'(i) || bus.imem_wdata !== prog[i]) begin
          bad++; $display("FAIL %s write %0d: got %0h:%0h want %0h:%0h", tag, i, bus.imem_addr, bus.imem_wdata, ADDR_W'(i), prog[i]);
        end
        i++;
      end
      if (bus.ld_ready !== 1'b1) begin
        fin = 1'b1;
      end else begin
        drv = (i < n) && ($urandom_range(99) >= bub);
        bus.ld_valid = drv;
        bus.ld_data  = drv ? prog[i] : $urandom;
        bus.ld_last  = drv ? (use_last && i == n - 1) : 1'($urandom_range(1));
        start = poke && ($urandom_range(3) == 0);
        @(negedge clk);
        guard++;
        if (guard > 3000) begin bad++; total++; $display("FAIL %s load bound: got %0d beats want %0d", tag, i, exp_words); fin = 1'b1; end
      end
    end
    // Now in RELEASE: outside LOAD these must be ignored.
    bus.ld_valid = 1'($urandom_range(1)); bus.ld_last = 1'b0;
    total++; if (i != exp_words || words !== (ADDR_W+1)'(exp_words)) begin bad++; $display("FAIL %s words: got %0d/%0d want %0d", tag, i, words, exp_words); end
    total++; if (core_rst !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL %s release: got rst=%0b busy=%0b want 1/1", tag, core_rst, busy); end

    @(negedge clk);
    total++; if (core_rst !== 1'b0 || pc !== 32'h0 || cycles !== '0) begin bad++; $display("FAIL %s run entry: got rst=%0b pc=%0h c=%0d want 0/0/0", tag, core_rst, pc, cycles); end
    lowcnt = 1; guard = 0; fin = 1'b0;
    while (!fin) begin
      start = poke && ($urandom_range(3) == 0);
      @(negedge clk);
      guard++;
      total++; if (bus.imem_we !== 1'b0) begin bad++; $display("FAIL %s run write: got %0b want 0", tag, bus.imem_we); end
      if (done === 1'b1) begin start = 1'b0; fin = 1'b1; end
      else if (core_rst === 1'b0) lowcnt++;
      if (!fin && guard > 1000) begin bad++; total++; $display("FAIL %s run bound: got no done want done", tag); start = 1'b0; fin = 1'b1; end
    end
    bus.ld_valid = 1'b0;
    total++; if (core_rst !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL %s done state: got rst=%0b busy=%0b want 1/0", tag, core_rst, busy); end
    total++; if (cycles !== CYC_W'(exp_c)) begin bad++; $display("FAIL %s cycles: got %0d want %0d", tag, cycles, exp_c); end
    total++; if (timeout !== exp_to) begin bad++; $display("FAIL %s timeout: got %0b want %0b", tag, timeout, exp_to); end
    total++; if (lowcnt != exp_c) begin bad++; $display("FAIL %s run length: got %0d want %0d", tag, lowcnt, exp_c); end
    repeat (2) @(negedge clk);
    total++; if (done !== 1'b1 || cycles !== CYC_W'(exp_c) || words !== (ADDR_W+1)'(exp_words)) begin
      bad++; $display("FAIL %s frozen: got d=%0b c=%0d w=%0d want 1/%0d/%0d", tag, done, cycles, words, exp_c, exp_words);
    end
    $display("%s: n=%0d halt=%0h max=%0d words=%0d cycles=%0d timeout=%0b", tag, n, hpc, mc, words, cycles, timeout);
  endtask

  task automatic test_halt();
    do_run("halt", 4, 1'b1, 32'h0C, 16'd0, 0, 1'b0);
  endtask

  task automatic test_budget();
    do_run("budget", 4, 1'b1, 32'hFFFF_FFFF, 16'd10, 0, 1'b0);
  endtask

  task automatic test_full();
    do_run("full", 300, 1'b0, 32'h08, 16'd0, 20, 1'b0);
  endtask

  task automatic test_edges();
    do_run("pc0", 3, 1'b1, 32'h0, 16'd5, 0, 1'b0);
    do_run("tie", 4, 1'b1, 32'h10, 16'd5, 0, 1'b0);
  endtask

  task automatic test_bubbles();
    do_run("bubble", 12, 1'b1, 32'h20, 16'd0, 50, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [31:0] h;
      logic [CYC_W-1:0] m;
      m = CYC_W'($urandom_range(30));
      h = ($urandom_range(3) == 0 && m != '0) ? 32'h0000_0102 : 32'($urandom_range(40)) << 2;
      do_run("random", int'($urandom_range(1, 20)), 1'b1, h, m, int'($urandom_range(60)), 1'($urandom_range(1)));
    end
  endtask

  task automatic test_abort_done();
    do_run("pre_abort", 2, 1'b1, 32'hFFFF_FFF0, 16'd3, 0, 1'b0);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    total++; if ({done, timeout, busy, bus.ld_ready} !== 4'b0000) begin bad++; $display("FAIL abort_done flags: got %b want 0000", {done, timeout, busy, bus.ld_ready}); end
    total++; if (cycles !== 16'd3 || words !== 9'd2) begin bad++; $display("FAIL abort_done hold: got %0d/%0d want 3/2", cycles, words); end
    $display("abort_done: done=%0b timeout=%0b", done, timeout);
  endtask

  task automatic test_abort_run();
    @(negedge clk);
    halt_pc = 32'hFFFF_FFF0; max_cycles = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = 32'h1234; bus.ld_last = 1'b1;
    @(negedge clk);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    total++; if (cycles !== 16'd4 || core_rst !== 1'b0) begin bad++; $display("FAIL abort_run pre: got c=%0d rst=%0b want 4/0", cycles, core_rst); end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    total++; if ({busy, done, core_rst} !== 3'b001) begin bad++; $display("FAIL abort_run state: got %b want 001", {busy, done, core_rst}); end
    total++; if (cycles !== 16'd4 || words !== 9'd1) begin bad++; $display("FAIL abort_run hold: got %0d/%0d want 4/1", cycles, words); end
    repeat (3) @(negedge clk);
    total++; if (bus.imem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_run idle: got we=%0b busy=%0b want 0/0", bus.imem_we, busy); end
    $display("abort_run: cycles=%0d words=%0d", cycles, words);
  endtask

  task automatic test_stop_load(input bit use_rst);
    logic [ADDR_W:0] exp_w;
    exp_w = use_rst ? 9'd0 : 9'd3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; bus.ld_valid = 1'b1; bus.ld_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.ld_data = 32'(k + 16);
      @(negedge clk);
    end
    bus.ld_data = 32'hDEAD;
    if (use_rst) rst = 1'b0; else abort = 1'b1;
    @(negedge clk);
    rst = 1'b1; abort = 1'b0;
    total++; if (bus.imem_we !== 1'b0 || bus.ld_ready !== 1'b0) begin bad++; $display("FAIL stop_load rst=%0b we/ready: got %0b/%0b want 0/0", use_rst, bus.imem_we, bus.ld_ready); end
    total++; if ({busy, done, core_rst} !== 3'b001) begin bad++; $display("FAIL stop_load rst=%0b state: got %b want 001", use_rst, {busy, done, core_rst}); end
    total++; if (words !== exp_w) begin bad++; $display("FAIL stop_load rst=%0b words: got %0d want %0d", use_rst, words, exp_w); end
    repeat (2) @(negedge clk);
    bus.ld_valid = 1'b0;
    total++; if (bus.imem_we !== 1'b0) begin bad++; $display("FAIL stop_load rst=%0b late write: got %0b want 0", use_rst, bus.imem_we); end
    $display("stop_load rst=%0b: words=%0d", use_rst, words);
  endtask

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    test_reset();
    test_halt();
    test_budget();
    test_full();
    test_edges();
    test_bubbles();
    test_random();
    test_abort_done();
    test_abort_run();
    test_stop_load(1'b0);
    test_stop_load(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Run controller for the single-cycle MIPS core. It streams a program into instruction memory over a valid/ready port while holding the core in reset. It then releases the core and counts execution cycles until the PC reaches a halt address or a cycle budget expires. It sits between the host/testbench and the `mips` instance and owns the core's reset and the imem write port.

## Interface
- `ADDR_W`, 8, imem word-address width (depth 2^ADDR_W words)
- `DATA_W`, 32, instruction word width
- `CYC_W`, 16, cycle-counter width

- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-low
- `start`  in  1  begin load+run; sampled in IDLE and DONE only
- `abort`  in  1  return to IDLE from any state
- `halt_pc`  in  32  stop address; captured when start is accepted
- `max_cycles`  in  CYC_W  run budget, 0 = unlimited; captured when start is accepted
- `ld_valid`  in  1  program beat valid
- `ld_ready`  out  1  program beat accepted when valid&ready
- `ld_data`  in  DATA_W  instruction word
- `ld_last`  in  1  final beat of program
- `imem_we`  out  1  imem write strobe (registered)
- `imem_addr`  out  ADDR_W  imem word address (registered)
- `imem_wdata`  out  DATA_W  imem write data (registered)
- `core_rst`  out  1  active-high reset to the core
- `pc`  in  32  current core PC
- `busy`  out  1  state is LOAD, RELEASE or RUN
- `done`  out  1  run finished, level until next start/abort
- `timeout`  out  1  qualifies done: budget expired, no halt
- `cycles`  out  CYC_W  RUN cycles executed
- `words`  out  ADDR_W+1  program words accepted

## Operation
- States: IDLE, LOAD, RELEASE, RUN, DONE. Outputs decode from the state register.
- `core_rst` = 1 in every state except RUN. `ld_ready` = 1 only in LOAD.
- IDLE: on `start`, clear `words`, `cycles`, `done`, `timeout`. Capture `halt_pc` and `max_cycles`. Go to LOAD.
- LOAD:
  - Each accepted beat writes `ld_data` at address `words[ADDR_W-1:0]`, then increments `words`.
  - Exit to RELEASE on a beat with `ld_last`=1, or on the beat written to address 2^ADDR_W-1 (forced last; there is no wrap).
  - `ld_valid` with no `ld_last` simply stalls; there is no timeout.
- RELEASE: exactly one cycle, which lets the final registered imem write land. Then go to RUN.
- RUN: `cycles` increments every cycle, including the terminating one. Checks in priority order:
  - `pc == halt_pc`: go to DONE, `timeout`=0.
  - else `max_cycles` != 0 and `cycles+1 == max_cycles`: go to DONE, `timeout`=1.
  - else, with `max_cycles`=0, `cycles` saturates at all-ones and RUN continues.
- DONE: `done`=1 and the core is held in reset. `cycles`/`words` are frozen. `start` re-enters LOAD with the same clears as from IDLE.
- `abort` in any state: next state IDLE, `done`/`timeout` cleared, `imem_we`=0 next cycle. `words`/`cycles` hold their values. `abort` has priority over `start` and over all RUN exits.
- `start` is ignored in LOAD, RELEASE and RUN. `ld_valid` is ignored outside LOAD.

## Timing
- Reset (`rst`=0 at a clk edge): state IDLE. `core_rst`=1. `ld_ready`, `imem_we`, `busy`, `done`, `timeout`=0. `imem_addr`, `imem_wdata`, `cycles`, `words`=0.
- `rst` mid-load or mid-run has the same effect: any in-flight beat is dropped and no write issues.
- Start latency: `start` high at edge N gives state LOAD and `ld_ready`=1 from cycle N+1.
- Write latency: a beat accepted at edge N produces `imem_we`=1 with that address and data during cycle N+1. Back-to-back beats give back-to-back writes.
- The last beat accepted at edge N gives RELEASE in cycle N+1 (last write visible) and RUN (`core_rst`=0) in cycle N+2.
- The first RUN cycle shows `pc`=0 and `cycles`=0.
- A RUN exit decided at edge M gives DONE with `done`=1 in cycle M+1 and `core_rst`=1 in that same cycle.

## Test plan
- Load 4 words (0xA..0xD, `ld_last` on the 4th), `halt_pc`=0x0C, `max_cycles`=0 -> writes at addresses 0..3 one cycle after each beat; `words`=4; done in the cycle after `pc`=0x0C; `timeout`=0; `cycles`=4 for straight-line code.
- Same program, `halt_pc`=0xFFFF_FFFF, `max_cycles`=10 -> `done`=1, `timeout`=1, `cycles`=10; `core_rst` was low for exactly 10 cycles.
- Stream 300 beats with `ADDR_W`=8, no `ld_last` -> exactly 256 writes at addresses 0..255; `words`=256; `ld_ready` drops after the 256th beat; RELEASE follows.
- `halt_pc`=0 -> halts on the first RUN cycle with `cycles`=1; a halt and a budget hit in the same cycle -> `timeout`=0.
- `abort` during RUN, and `rst`=0 during LOAD with `ld_valid` high -> IDLE next cycle, `core_rst`=1, no further `imem_we`, `done`=0.
- `ld_valid` toggling (bubbles) and `start` pulsed during LOAD/RUN -> only handshaken beats are written, and the `start` pulses are ignored.
